ysyx22041405_pipe_stage: RTL and testbench
==========================================

# ysyx22041405_pipe_stage

Parametrised handshaked pipeline-stage register that replaces the bare write-enable stage registers between IFU/IDU/EXU/MEM/WBU. It moves a WIDTH-bit stage message from producer to consumer under a valid/ready handshake, supports a synchronous flush for branch/exception redirect, and optionally uses a two-entry skid buffer so `in_ready` is a register output. A saturating stall counter feeds performance debug.

## Interface
- `WIDTH`, 64, stage message width (IF/ID = {pc, inst})
- `CNT_W`, 16, stall-counter width
- `clk` in 1, clock, all state on rising edge
- `rst` in 1, reset, asynchronous, active-high
- `in_valid` in 1, producer has a message
- `in_ready` out 1, stage accepts a message this cycle
- `in_data` in WIDTH, producer message
- `out_valid` out 1, stage holds a message for the consumer
- `out_ready` in 1, consumer accepts this cycle
- `out_data` out WIDTH, message at stage head
- `flush` in 1, discard all held and incoming messages
- `stall_cnt` out CNT_W, cycles with `out_valid && !out_ready`, saturating

## Operation
- Transfers: in-fire = `in_valid && in_ready`; out-fire = `out_valid && out_ready`.
- States: EMPTY, FULL (main entry valid), SKID (main and skid valid).
- EMPTY: in-fire -> FULL, main <= in_data.
- FULL: in-fire & out-fire -> FULL, main <= in_data; in-fire & !out-fire -> SKID, skid <= in_data; out-fire & !in-fire -> EMPTY; neither -> FULL.
- SKID: in-fire impossible; out-fire -> FULL, main <= skid; else hold.
- `out_valid` = state != EMPTY; `out_data` = main; `in_ready` = state != SKID.
- Flush: highest priority; next state EMPTY regardless of in/out fire; message presented that cycle dropped even if `in_ready`=1; data registers not cleared.
- Messages leave strictly in acceptance order; none duplicated or lost except by flush.
- `stall_cnt`: +1 per cycle with `out_valid && !out_ready`; sticks at 2^CNT_W-1; not cleared by flush; cleared only by reset.

## Timing
- Latency: message accepted at edge N appears on `out_data` with `out_valid`=1 after edge N (earliest out-fire in cycle N+1).
- Throughput: one message/cycle sustained when `out_ready` held 1.
- `in_ready`, `out_valid`, `out_data` are pure register outputs (with macro); no combinational path from `out_ready` or `in_valid` to any output.
- Reset (asynchronous, immediate): state EMPTY, main = skid = 0, `out_valid`=0, `in_ready`=1, `out_data`=0, `stall_cnt`=0.
- Reset mid-operation: held messages lost; first edge after deassertion may accept a message.
- Flush and reset: both return to EMPTY; flush does not touch the counter.

## Configuration
- `YSYX22041405_PIPE_SKID_EN` defined: two-entry skid behaviour above, `in_ready` registered.
- Undefined: single entry, SKID state never entered; `in_ready` = `!out_valid || out_ready` (combinational from `out_ready`); FULL with in-fire & !out-fire is impossible. Latency, ordering, flush, counter unchanged.

## Structure
- Shared package `ysyx22041405_pipe_pkg`: stage-state typedef (EMPTY/FULL/SKID) and per-stage message widths (IF/ID, ID/EX, EX/MEM, MEM/WB).
- One sub-module: `ysyx22041405_sat_counter` (parametrised width, enable, async reset) for `stall_cnt`.

## Test plan
- Reset: assert `rst` mid-simulation asynchronously -> same cycle `out_valid`=0, `in_ready`=1, `stall_cnt`=0, `out_data`=0.
- Streaming: `out_ready`=1, push 0x1..0x8 back-to-back -> out 0x1..0x8 in order, one per cycle, one-cycle latency, `stall_cnt`=0.
- Backpressure (macro on): push 0xA, 0xB with `out_ready`=0 -> state SKID, `in_ready`=0, `out_data`=0xA; raise `out_ready` -> 0xA then 0xB, `in_ready` returns 1 after first out-fire.
- Flush: hold 0xA, 0xB in SKID, assert `flush` with `in_valid`=1 data 0xC -> next cycle EMPTY, `out_valid`=0; 0xC never appears.
- Counter saturation: CNT_W=4, `out_valid`=1, `out_ready`=0 for 20 cycles -> `stall_cnt`=15 and holds.
- Macro off: `out_valid`=1, `out_ready`=0 -> `in_ready`=0; `out_ready`=1 same cycle -> `in_ready`=1 and in/out fire together.

Source files
------------

// File: rtl/ysyx22041405_pipe_pkg.sv
// Shared definitions for the handshaked pipeline-stage registers:
// stage occupancy state and the per-stage message widths.
package ysyx22041405_pipe_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL  = 2'd1,
        ST_SKID  = 2'd2
    } stage_state_e;

    localparam int unsigned PC_W    = 32;
    localparam int unsigned INST_W  = 32;
    localparam int unsigned XLEN    = 64;

    // IF/ID carries {pc, inst}
    localparam int unsigned IF_ID_W  = PC_W + INST_W;
    // ID/EX carries {pc, inst, rs1 value, rs2 value, imm}
    localparam int unsigned ID_EX_W  = PC_W + INST_W + 3 * XLEN;
    // EX/MEM carries {pc, inst, alu result, store data}
    localparam int unsigned EX_MEM_W = PC_W + INST_W + 2 * XLEN;
    // MEM/WB carries {pc, inst, writeback value}
    localparam int unsigned MEM_WB_W = PC_W + INST_W + XLEN;

    localparam int unsigned STALL_CNT_W = 16;

endpackage

// File: rtl/ysyx22041405_sat_counter.sv
// Saturating up-counter: increments on en_i, sticks at all-ones,
// cleared only by the asynchronous active-high reset.
module ysyx22041405_sat_counter #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q;

    // Count enabled cycles until the maximum value is reached
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (en_i && (cnt_q != {W{1'b1}})) begin
            cnt_q <= cnt_q + W'(1);
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/ysyx22041405_pipe_stage.sv
// Handshaked pipeline-stage register with flush and a saturating stall counter.
// Define YSYX22041405_PIPE_SKID_EN for the two-entry skid version, in which
// in_ready is a register output; otherwise a single entry is held and
// in_ready is derived combinationally from out_ready.
module ysyx22041405_pipe_stage
    import ysyx22041405_pipe_pkg::*;
#(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    input  logic             flush,
    output logic [CNT_W-1:0] stall_cnt
);

    stage_state_e     state_q, state_d;
    logic [WIDTH-1:0] main_q, main_d;
    logic             out_valid_q, out_valid_d;
    logic             in_fire;
    logic             out_fire;

`ifdef YSYX22041405_PIPE_SKID_EN
    logic [WIDTH-1:0] skid_q, skid_d;
    logic             in_ready_q, in_ready_d;

    assign in_ready = in_ready_q;
`else
    // Single entry: free when empty or when the held message leaves this cycle
    assign in_ready = !out_valid_q || out_ready;
`endif

    assign in_fire  = in_valid && in_ready;
    assign out_fire = out_valid_q && out_ready;

    // Next-state and datapath selection; flush overrides every transfer
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
`ifdef YSYX22041405_PIPE_SKID_EN
        skid_d  = skid_q;
`endif

        case (state_q)
            ST_EMPTY: begin
                if (in_fire) begin
                    state_d = ST_FULL;
                    main_d  = in_data;
                end
            end
            ST_FULL: begin
                if (in_fire && out_fire) begin
                    main_d = in_data;
                end else if (in_fire) begin
`ifdef YSYX22041405_PIPE_SKID_EN
                    state_d = ST_SKID;
                    skid_d  = in_data;
`endif
                end else if (out_fire) begin
                    state_d = ST_EMPTY;
                end
            end
`ifdef YSYX22041405_PIPE_SKID_EN
            ST_SKID: begin
                if (out_fire) begin
                    state_d = ST_FULL;
                    main_d  = skid_q;
                end
            end
`endif
            default: begin
                state_d = ST_EMPTY;
            end
        endcase

        // Redirect: drop held and incoming messages, leave data untouched
        if (flush) begin
            state_d = ST_EMPTY;
            main_d  = main_q;
`ifdef YSYX22041405_PIPE_SKID_EN
            skid_d  = skid_q;
`endif
        end

        out_valid_d = (state_d != ST_EMPTY);
`ifdef YSYX22041405_PIPE_SKID_EN
        in_ready_d  = (state_d != ST_SKID);
`endif
    end

    // State, payload and registered handshake outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_EMPTY;
            main_q      <= '0;
            out_valid_q <= 1'b0;
`ifdef YSYX22041405_PIPE_SKID_EN
            skid_q      <= '0;
            in_ready_q  <= 1'b1;
`endif
        end else begin
            state_q     <= state_d;
            main_q      <= main_d;
            out_valid_q <= out_valid_d;
`ifdef YSYX22041405_PIPE_SKID_EN
            skid_q      <= skid_d;
            in_ready_q  <= in_ready_d;
`endif
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = main_q;

    // Cycles where the consumer holds back a presented message
    ysyx22041405_sat_counter #(
        .W (CNT_W)
    ) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .en_i  (out_valid_q && !out_ready),
        .cnt_o (stall_cnt)
    );

endmodule

// File: tb/tb_ysyx22041405_pipe_stage.sv
// Scoreboard bench for ysyx22041405_pipe_stage (works with or without
// YSYX22041405_PIPE_SKID_EN). The driver owns an occupancy model of the stage
// and pushes accepted messages into an expected queue; a separate monitor pops
// and compares whenever the consumer side fires.
module tb_ysyx22041405_pipe_stage;

    localparam int unsigned WIDTH = 64;
    localparam int unsigned CNT_W = 4;
    localparam int          CNT_MAX = (1 << CNT_W) - 1;
`ifdef YSYX22041405_PIPE_SKID_EN
    localparam int          CAP = 2;
`else
    localparam int          CAP = 1;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             flush;
    logic [CNT_W-1:0] stall_cnt;

    ysyx22041405_pipe_stage #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .flush     (flush),
        .stall_cnt (stall_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [WIDTH-1:0] exp_q[$];
    int               occ     = 0;
    int               stall_m = 0;

    bit               pend_valid = 0;
    bit               pend_flush;
    bit               pend_push;
    logic [WIDTH-1:0] pend_data;
    int               pend_occ;
    int               pend_stall;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Commit the model effects of the previous cycle at the clock edge
    task automatic apply_pending();
        if (pend_valid) begin
            if (pend_flush) exp_q.delete();
            else if (pend_push) exp_q.push_back(pend_data);
            occ        = pend_occ;
            stall_m    = pend_stall;
            pend_valid = 0;
        end
    endtask

    // One clock cycle of stimulus plus control-signal checks
    task automatic cycle(input logic iv, input logic [WIDTH-1:0] d,
                         input logic ordy, input logic fl);
        bit m_ir, in_f, out_f;
        @(posedge clk);
        apply_pending();
        #1;
        in_valid  = iv;
        in_data   = d;
        out_ready = ordy;
        flush     = fl;
        #1;
        m_ir = (CAP == 2) ? (occ < 2) : ((occ == 0) || ordy);
        chk("in_ready", 64'(in_ready), 64'(m_ir));
        chk("out_valid", 64'(out_valid), 64'(occ != 0));
        chk("stall_cnt", 64'(stall_cnt), 64'(stall_m));
        in_f = iv && m_ir;
        out_f = (occ != 0) && ordy;
        pend_flush = fl;
        pend_push  = in_f && !fl;
        pend_data  = d;
        pend_occ   = fl ? 0 : occ + int'(in_f) - int'(out_f);
        pend_stall = ((occ != 0) && !ordy && (stall_m < CNT_MAX)) ? stall_m + 1 : stall_m;
        pend_valid = 1;
    endtask

    // Asynchronous reset in the middle of a cycle, checked before any edge
    task automatic mid_reset();
        @(posedge clk);
        apply_pending();
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        flush     = 1'b0;
        #1;
        rst = 1'b1;
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_stall_cnt", 64'(stall_cnt), 64'd0);
        chk("rst_out_data", out_data, 64'd0);
        exp_q.delete();
        occ     = 0;
        stall_m = 0;
        @(negedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Monitor: every consumer-side transfer must match the oldest expected message
    initial begin
        forever begin
            @(negedge clk);
            if (!rst && out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("out_unexpected", out_data, 64'hx);
                end else begin
                    chk("out_data", out_data, exp_q[0]);
                    void'(exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        flush     = 1'b0;
        #2;
        chk("init_out_valid", 64'(out_valid), 64'd0);
        chk("init_in_ready", 64'(in_ready), 64'd1);
        chk("init_stall_cnt", 64'(stall_cnt), 64'd0);
        chk("init_out_data", out_data, 64'd0);
        @(posedge clk);
        @(negedge clk);
        #1;
        rst = 1'b0;

        // Streaming 1..8 with the consumer always ready
        for (int i = 1; i <= 8; i++) cycle(1'b1, WIDTH'(i), 1'b1, 1'b0);
        for (int i = 0; i < 2; i++) cycle(1'b0, '0, 1'b1, 1'b0);

        // Backpressure: fill, then release
        cycle(1'b1, 64'hA, 1'b0, 1'b0);
        cycle(1'b1, 64'hB, 1'b0, 1'b0);
        cycle(1'b0, '0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) cycle(1'b0, '0, 1'b1, 1'b0);

        // Flush while full, with a message offered in the same cycle
        cycle(1'b1, 64'hA, 1'b0, 1'b0);
        cycle(1'b1, 64'hB, 1'b0, 1'b0);
        cycle(1'b1, 64'hC, 1'b0, 1'b1);
        for (int i = 0; i < 2; i++) cycle(1'b0, '0, 1'b1, 1'b0);

        // Counter saturation under a long stall
        cycle(1'b1, 64'h5, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) cycle(1'b0, '0, 1'b0, 1'b0);

        // Reset with a message held and a saturated counter
        mid_reset();
        cycle(1'b1, 64'h77, 1'b1, 1'b0);
        cycle(1'b0, '0, 1'b1, 1'b0);

        // Randomised traffic
        for (int i = 0; i < 600; i++) begin
            logic [WIDTH-1:0] d;
            d = {$urandom(), $urandom()};
            cycle(1'($urandom_range(0, 99) < 70), d,
                  1'($urandom_range(0, 99) < 60),
                  1'($urandom_range(0, 99) < 5));
        end

        // Drain and confirm nothing is left outstanding
        for (int i = 0; i < 4; i++) cycle(1'b0, '0, 1'b1, 1'b0);
        @(posedge clk);
        apply_pending();
        #2;
        chk("drain_empty", 64'(exp_q.size()), 64'd0);
        chk("drain_out_valid", 64'(out_valid), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
